// File: rtl/sched_pkg.sv
// Shared types and helpers for the timeslice scheduler.
// States, default widths, the reset slice length and the round-robin pick.
package sched_pkg;

    localparam int TASK_W_DEFAULT = 2;
    localparam int W_DEFAULT      = 16;
    localparam logic [15:0] SLICE_DEFAULT = 16'd1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        PEND  = 2'd3
    } state_t;

    // Search cur+1, cur+2, ... modulo ntask with cur itself last; first set
    // bit of valid wins. Returns cur when nothing is valid. Passing
    // cur = ntask-1 yields the lowest-index valid task.
    function automatic logic [2:0] rr_next(input logic [7:0] valid,
                                           input logic [2:0] cur,
                                           input int         ntask);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && k <= ntask) begin
                idx = 3'((int'(cur) + k) % ntask);
                if (valid[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/slice_counter.sv
// Countdown counter for the active time slice: load, clear, and
// decrement that stops at zero, with zero/one flags for the scheduler.
module slice_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         one
);

    // Clear beats load beats decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_data;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
    assign one  = (count == W'(1));

endmodule

// File: rtl/timeslice_scheduler.sv
// Round-robin preemption scheduler: per-task slice table, shared countdown
// counter, and an irq/ack handshake with the CPU for each task switch.
// Optional: define SCHED_YIELD_EN to add a yield input that ends the
// running slice early.
module timeslice_scheduler
    import sched_pkg::*;
#(
    parameter int           NTASK         = 4,
    parameter int           TASK_W        = TASK_W_DEFAULT,
    parameter int           W             = W_DEFAULT,
    parameter logic [W-1:0] DEFAULT_SLICE = W'(SLICE_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NTASK-1:0]  task_valid,
    input  logic              cfg_we,
    input  logic [TASK_W-1:0] cfg_addr,
    input  logic [W-1:0]      cfg_data,
`ifdef SCHED_YIELD_EN
    input  logic              yield,
`endif
    output logic              irq,
    input  logic              irq_ack,
    output logic [TASK_W-1:0] cur_task,
    output logic [TASK_W-1:0] next_task,
    output logic [W-1:0]      remaining,
    output logic              busy
);

    state_t            state, state_n;
    logic              irq_n;
    logic [TASK_W-1:0] cur_task_n, next_task_n;
    logic              cnt_load, cnt_clear, cnt_dec;
    logic              cnt_zero, cnt_one;
    logic [W-1:0]      slice_tbl [NTASK];
    logic [W-1:0]      slice_cur, load_val;
    logic [TASK_W-1:0] rr_pick, first_pick;
    logic              yield_req;

`ifdef SCHED_YIELD_EN
    assign yield_req = yield;
`else
    assign yield_req = 1'b0;
`endif

    assign rr_pick    = TASK_W'(rr_next(8'(task_valid), 3'(cur_task), NTASK));
    assign first_pick = TASK_W'(rr_next(8'(task_valid), 3'(NTASK - 1), NTASK));

    // A zero-length slice still runs for one cycle.
    assign slice_cur = slice_tbl[cur_task];
    assign load_val  = (slice_cur == '0) ? W'(1) : slice_cur;

    // Slice table: CPU writes land at any time; LOAD reads the pre-write value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTASK; i++) begin
                slice_tbl[i] <= DEFAULT_SLICE;
            end
        end else if (cfg_we) begin
            slice_tbl[cfg_addr] <= cfg_data;
        end
    end

    slice_counter #(.W(W)) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .load_data (load_val),
        .dec       (cnt_dec),
        .count     (remaining),
        .zero      (cnt_zero),
        .one       (cnt_one)
    );

    // Scheduler state, interrupt and task registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            irq       <= 1'b0;
            cur_task  <= '0;
            next_task <= '0;
        end else begin
            state     <= state_n;
            irq       <= irq_n;
            cur_task  <= cur_task_n;
            next_task <= next_task_n;
        end
    end

    // Next-state, counter control and task selection.
    always_comb begin
        state_n     = state;
        irq_n       = irq;
        cur_task_n  = cur_task;
        next_task_n = next_task;
        cnt_load    = 1'b0;
        cnt_clear   = 1'b0;
        cnt_dec     = 1'b0;
        if (!enable) begin
            state_n   = IDLE;
            irq_n     = 1'b0;
            cnt_clear = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|task_valid) begin
                        cur_task_n = first_pick;
                        state_n    = LOAD;
                    end
                end
                LOAD: begin
                    cnt_load = 1'b1;
                    state_n  = COUNT;
                end
                COUNT: begin
                    if (cnt_one || cnt_zero || yield_req) begin
                        cnt_clear   = 1'b1;
                        irq_n       = 1'b1;
                        next_task_n = rr_pick;
                        state_n     = PEND;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                PEND: begin
                    next_task_n = rr_pick;
                    if (irq_ack) begin
                        irq_n = 1'b0;
                        if (|task_valid) begin
                            cur_task_n = rr_pick;
                            state_n    = LOAD;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_timeslice_scheduler.sv
// Scoreboard bench for timeslice_scheduler: stimulus queues expected output
// snapshots and irq events; a negedge monitor pops and compares them.
module tb_timeslice_scheduler;

    localparam int NTASK  = 4;
    localparam int TASK_W = 2;
    localparam int W      = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NTASK-1:0]  task_valid;
    logic              cfg_we;
    logic [TASK_W-1:0] cfg_addr;
    logic [W-1:0]      cfg_data;
    logic              irq;
    logic              irq_ack;
    logic [TASK_W-1:0] cur_task;
    logic [TASK_W-1:0] next_task;
    logic [W-1:0]      remaining;
    logic              busy;
`ifdef SCHED_YIELD_EN
    logic              yield;
`endif

    timeslice_scheduler #(.NTASK(NTASK), .TASK_W(TASK_W), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .task_valid (task_valid),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
`ifdef SCHED_YIELD_EN
        .yield      (yield),
`endif
        .irq        (irq),
        .irq_ack    (irq_ack),
        .cur_task   (cur_task),
        .next_task  (next_task),
        .remaining  (remaining),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    irq;
        int    cur;
        int    nxt;   // -1 = not checked
        int    rem;
        int    busy;
    } exp_t;

    typedef struct {
        int nxt;
        int len;
    } irq_exp_t;

    exp_t     sb_q[$];
    irq_exp_t irq_q[$];
    int       checks = 0;
    int       errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int i, input int c,
                              input int n, input int r, input int b);
        exp_t e;
        e.name = name; e.irq = i; e.cur = c; e.nxt = n; e.rem = r; e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic expect_irq(input int n, input int len);
        irq_exp_t e;
        e.nxt = n; e.len = len;
        irq_q.push_back(e);
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = TASK_W'(addr);
        cfg_data = W'(data);
    endtask

    // Monitor: compare queued snapshots, and check each irq rise against the
    // expected next task and the number of cycles the counter was nonzero.
    initial begin
        exp_t     e;
        irq_exp_t ie;
        int       run = 0;
        int       last_run = 0;
        logic     irq_d = 1'b0;
        bit       ok;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                ok = (int'(irq) == e.irq) && (int'(cur_task) == e.cur) &&
                     (e.nxt < 0 || int'(next_task) == e.nxt) &&
                     (int'(remaining) == e.rem) && (int'(busy) == e.busy);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got irq=%0d cur=%0d next=%0d rem=%0d busy=%0d, want irq=%0d cur=%0d next=%0d rem=%0d busy=%0d",
                             e.name, irq, cur_task, next_task, remaining, busy,
                             e.irq, e.cur, e.nxt, e.rem, e.busy);
                end
            end
            if (remaining != '0) begin
                run++;
            end else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            if (reset) begin
                run = 0;
                last_run = 0;
            end
            if (irq && !irq_d) begin
                checks++;
                if (irq_q.size() == 0) begin
                    errors++;
                    $display("FAIL irq_event: unexpected irq, next=%0d len=%0d", next_task, last_run);
                end else begin
                    ie = irq_q.pop_front();
                    if (int'(next_task) != ie.nxt || last_run != ie.len) begin
                        errors++;
                        $display("FAIL irq_event: got next=%0d len=%0d, want next=%0d len=%0d",
                                 next_task, last_run, ie.nxt, ie.len);
                    end
                end
            end
            irq_d = irq;
        end
    end

    // Watchdog: the directed run is short; stopping here means a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; task_valid = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; irq_ack = 1'b0;
`ifdef SCHED_YIELD_EN
        yield = 1'b0;
`endif
        step();
        step();
        expect_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Slice 3 for task 0, slice 5 for task 2, tasks {0,2} runnable.
        cfg_write(0, 3);
        step();
        cfg_write(2, 5);
        step();
        cfg_we = 1'b0;
        enable = 1'b1;
        task_valid = 4'b0101;
        expect_irq(2, 3);
        step(); expect_out("load_t0", 0, 0, -1, 0, 1);
        step(); expect_out("cnt3", 0, 0, -1, 3, 1);
        step(); expect_out("cnt2", 0, 0, -1, 2, 1);
        step(); expect_out("cnt1", 0, 0, -1, 1, 1);
        step(); expect_out("pend_t0", 1, 0, 2, 0, 1);
        step(); expect_out("pend_hold", 1, 0, 2, 0, 1);

        // Ack switches to task 2; 5-cycle slice then wrap back to task 0.
        irq_ack = 1'b1;
        expect_irq(0, 5);
        step(); expect_out("ack_t2", 0, 2, 2, 0, 1);
        irq_ack = 1'b0;
        for (int k = 5; k >= 1; k--) begin
            step(); expect_out("cnt_t2", 0, 2, -1, k, 1);
        end
        step(); expect_out("pend_wrap", 1, 2, 0, 0, 1);

        // Ack with nothing runnable drops to IDLE.
        task_valid = 4'b0000;
        irq_ack = 1'b1;
        step(); expect_out("ack_idle", 0, 2, -1, 0, 0);
        irq_ack = 1'b0;

        // Zero slice for task 1 runs one cycle; only task 1 runnable.
        cfg_write(1, 0);
        task_valid = 4'b0010;
        expect_irq(1, 1);
        step(); expect_out("load_t1", 0, 1, -1, 0, 1);
        cfg_we = 1'b0;
        step(); expect_out("cnt_zero_slice", 0, 1, -1, 1, 1);
        step(); expect_out("pend_self", 1, 1, 1, 0, 1);

        // Rewrite during COUNT leaves this slice alone; a write during LOAD
        // is not seen by that LOAD either.
        irq_ack = 1'b1;
        expect_irq(1, 1);
        step(); expect_out("ack_t1", 0, 1, 1, 0, 1);
        irq_ack = 1'b0;
        step(); expect_out("cnt_old", 0, 1, -1, 1, 1);
        cfg_write(1, 7);
        step(); expect_out("pend_old", 1, 1, 1, 0, 1);
        cfg_we = 1'b0;
        irq_ack = 1'b1;
        expect_irq(1, 7);
        step(); expect_out("load_new", 0, 1, 1, 0, 1);
        irq_ack = 1'b0;
        cfg_write(1, 2);
        for (int k = 7; k >= 1; k--) begin
            step(); expect_out("cnt_seven", 0, 1, -1, k, 1);
            cfg_we = 1'b0;
        end
        step(); expect_out("pend_seven", 1, 1, 1, 0, 1);

        // Dropping enable in PEND clears irq; ack in IDLE does nothing.
        enable = 1'b0;
        step(); expect_out("disable_pend", 0, 1, -1, 0, 0);
        irq_ack = 1'b1;
        step(); expect_out("ack_in_idle", 0, 1, -1, 0, 0);
        irq_ack = 1'b0;

        // Reset in the middle of a slice (task 1 now has slice 2).
        enable = 1'b1;
        step(); expect_out("load_before_rst", 0, 1, -1, 0, 1);
        step(); expect_out("cnt_before_rst", 0, 1, -1, 2, 1);
        reset = 1'b1;
        step(); expect_out("reset_mid", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Table back at the default slice after reset.
        task_valid = 4'b0001;
        step(); expect_out("load_dflt", 0, 0, -1, 0, 1);
        step(); expect_out("cnt_dflt", 0, 0, -1, 1000, 1);
`ifdef SCHED_YIELD_EN
        for (int k = 0; k < 600; k++) step();
        expect_out("cnt_400", 0, 0, -1, 400, 1);
        yield = 1'b1;
        expect_irq(0, 601);
        step(); expect_out("yield_pend", 1, 0, 0, 0, 1);
        yield = 1'b0;
`endif
        enable = 1'b0;
        step(); expect_out("final_idle", 0, 0, -1, 0, 0);
        step();
        @(negedge clk);
        #1;
        checks++;
        if (irq_q.size() != 0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d irq events and %0d snapshots pending, want 0 and 0",
                     irq_q.size(), sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
